conv_mac_unit: RTL and testbench
================================

Name: conv_mac_unit

Overview:
- Downstream consumer of the kernel-serving weight stage.
- Requests one K_H x K_W kernel at a time and latches it on the weight stage's one-cycle kernel pulse.
- Slides the kernel over a captured IMG_H x IMG_W feature map (stride 1, no padding) and emits one signed accumulated result per window over a valid/ready output port.
- Repeats for NUM_KERNELS kernels, then pulses done.

Parameters:
- DATA_WIDTH, 8: width of each signed pixel/weight element.
- K_H, 3: kernel rows.
- K_W, 3: kernel columns.
- NUM_KERNELS, 3: kernels processed per start.
- IMG_H, 5: feature map rows.
- IMG_W, 5: feature map columns.
- ACC_WIDTH, 2*DATA_WIDTH+4: accumulator and result width; must be >= 2*DATA_WIDTH+clog2(K_H*K_W).

Ports:
- clk, input, 1: clock; rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin job; sampled only in IDLE.
- image_in, input, DATA_WIDTH*IMG_H*IMG_W: row-major feature map; element (r,c) at bits [(r*IMG_W+c)*DATA_WIDTH +: DATA_WIDTH].
- kernel_in, input, DATA_WIDTH*K_H*K_W: row-major kernel from the weight stage.
- kernel_valid, input, 1: one-cycle pulse; kernel_in valid this cycle.
- weights_done, input, 1: weight stage has no more kernels.
- next_kernel, output, 1: kernel request, held until kernel_valid.
- out_value, output, ACC_WIDTH: signed window result.
- out_valid, output, 1: out_value valid.
- out_ready, input, 1: consumer accepts out_value.
- out_kernel, output, clog2(NUM_KERNELS) (min 1): index of the kernel that produced out_value.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle completion pulse.
- err_short, output, 1: sticky; weights_done seen before NUM_KERNELS kernels were received.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0. rst_n is asserted mid-job: abort immediately, no done pulse; err_short clears.
- Output geometry: OH = IMG_H-K_H+1, OW = IMG_W-K_W+1; windows are processed row-major.
- IDLE:
  - When start is high: capture image_in into an internal register, clear err_short and kernel counter kc, then go to REQ.
  - start is ignored in every other state.
- REQ:
  - next_kernel = 1.
  - When kernel_valid is high: latch kernel_in, window row/col = 0, go to MAC. next_kernel is low from the next cycle.
  - When weights_done is high and kernel_valid is low: set err_short, go to FIN.
  - kernel_valid outside REQ is ignored.
- MAC:
  - One signed multiply-accumulate per cycle over tap index t = 0..K_H*K_W-1.
  - Product: pixel(row+t/K_W, col+t%K_W) * weight(t), sign-extended to ACC_WIDTH.
  - Accumulator clears at t = 0.
  - After the last tap, go to OUT. Latency: K_H*K_W cycles from MAC entry to out_valid.
- OUT:
  - out_valid = 1; out_value and out_kernel are held stable until out_ready is high.
  - On handshake: advance col; at col = OW-1, wrap col to 0 and increment row.
  - Last window (row OH-1, col OW-1): increment kc. If kc reaches NUM_KERNELS, go to FIN; otherwise go to REQ.
  - Any other window: go to MAC.
  - out_valid is low in the cycle after the handshake.
- FIN: done = 1 for one cycle, then go to IDLE.
- Arithmetic: two's complement throughout. The accumulator is wide enough that no overflow occurs at the parameter constraint.
- Throughput: one result per K_H*K_W+1 cycles with out_ready held high.
- Stall: out_ready low freezes the FSM in OUT. No result is dropped or duplicated.

Optional Feature:
- Macro: CONV_MAC_RELU_EN.
- Defined: out_value is forced to 0 when the accumulated result is negative. The accumulator itself is unaffected.
- Undefined: raw signed accumulated result on out_value. Timing is identical in both builds.

Test Plan:
- Defaults; image all 1; three kernels all 1 served on request -> 27 results, each value 9, out_kernel 0,0..,1..,2; done pulses once after the 27th handshake; err_short = 0.
- Image pixel(r,c) = r*5+c; kernel with only center tap = 2 -> results for kernel 0 in order 12,14,16,22,24,26,32,34,36.
- Image all -128; kernel all 127 -> each result -146304 with macro undefined; 0 with CONV_MAC_RELU_EN defined.
- out_ready low for 10 cycles at the 4th result -> out_valid held, out_value stable; no extra results; total count stays 27.
- Serve only 1 kernel, then pulse weights_done while in REQ -> 9 results, err_short = 1, done pulses; the next start clears err_short.
- Deassert rst_n during MAC of the 5th window -> all outputs 0 on the same edge, IDLE; a fresh start reruns the full job correctly.

Source files
------------

// File: rtl/conv_mac_unit.sv
// conv_mac_unit
// -------------
// Consumer of the kernel-serving weight stage. On start it captures a
// row-major IMG_H x IMG_W feature map. For each of NUM_KERNELS kernels it
// requests a kernel and latches it on the weight stage's one-cycle pulse.
// It then slides the kernel over the map (stride 1, no padding). Each
// window result takes K_H*K_W cycles of serial signed multiply-accumulate.
//
// Handshake: out_value/out_kernel are valid while out_valid is high and stay
// frozen until the cycle out_ready is also high; that edge is the transfer,
// and out_valid is low in the following cycle.
//
// Optional build macro CONV_MAC_RELU_EN: negative results are presented as 0
// on out_value (accumulator untouched, timing identical).
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 begin job (sampled only when idle)
//   image_in              feature map, element (r,c) at [(r*IMG_W+c)*DATA_WIDTH +: DATA_WIDTH]
//   kernel_in             row-major kernel, valid with kernel_valid pulse
//   kernel_valid          one-cycle kernel pulse from the weight stage
//   weights_done          weight stage has no more kernels
//   next_kernel           kernel request, held until kernel_valid
//   out_value/out_valid   signed window result / valid
//   out_ready             consumer accepts out_value
//   out_kernel            index of kernel that produced out_value
//   busy, done            not idle / one-cycle completion pulse
//   err_short             sticky: weights ran out before NUM_KERNELS kernels
//   dbg_state             current FSM state encoding
module conv_mac_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int K_H         = 3,
  parameter int K_W         = 3,
  parameter int NUM_KERNELS = 3,
  parameter int IMG_H       = 5,
  parameter int IMG_W       = 5,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [DATA_WIDTH*IMG_H*IMG_W-1:0]            image_in,
  input  logic [DATA_WIDTH*K_H*K_W-1:0]                kernel_in,
  input  logic                                         kernel_valid,
  input  logic                                         weights_done,
  output logic                                         next_kernel,
  output logic [ACC_WIDTH-1:0]                         out_value,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [((NUM_KERNELS>1)?$clog2(NUM_KERNELS):1)-1:0] out_kernel,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err_short,
  output logic [2:0]                                   dbg_state
);

  localparam int OH  = IMG_H - K_H + 1;
  localparam int OW  = IMG_W - K_W + 1;
  localparam int KIW = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int KCW = $clog2(NUM_KERNELS + 1);
  localparam int ORW = (OH > 1) ? $clog2(OH) : 1;
  localparam int OCW = (OW > 1) ? $clog2(OW) : 1;
  localparam int TRW = (K_H > 1) ? $clog2(K_H) : 1;
  localparam int TCW = (K_W > 1) ? $clog2(K_W) : 1;
  localparam int IRW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int ICW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [KCW-1:0] KC_LAST = KCW'(NUM_KERNELS - 1);
  localparam logic [ORW-1:0] OR_LAST = ORW'(OH - 1);
  localparam logic [OCW-1:0] OC_LAST = OCW'(OW - 1);
  localparam logic [TRW-1:0] TR_LAST = TRW'(K_H - 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(K_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_MAC, S_OUT, S_FIN} state_t;

  state_t                            state;
  logic [DATA_WIDTH*IMG_H*IMG_W-1:0] image_reg;
  logic [DATA_WIDTH*K_H*K_W-1:0]     ker_reg;
  logic [KCW-1:0]                    kc;
  logic [ORW-1:0]                    row;
  logic [OCW-1:0]                    col;
  logic [TRW-1:0]                    tap_r;
  logic [TCW-1:0]                    tap_c;
  logic signed [ACC_WIDTH-1:0]       acc;

  logic [DATA_WIDTH-1:0] img_arr [IMG_H][IMG_W];
  logic [DATA_WIDTH-1:0] ker_arr [K_H][K_W];

  for (genvar r = 0; r < IMG_H; r++) begin : g_img_r
    for (genvar c = 0; c < IMG_W; c++) begin : g_img_c
      assign img_arr[r][c] = image_reg[(r*IMG_W+c)*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  for (genvar r = 0; r < K_H; r++) begin : g_ker_r
    for (genvar c = 0; c < K_W; c++) begin : g_ker_c
      assign ker_arr[r][c] = ker_reg[(r*K_W+c)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Tap (tap_r, tap_c) of window (row, col) reads pixel (row+tap_r, col+tap_c).
  logic [IRW-1:0]                pix_r;
  logic [ICW-1:0]                pix_c;
  logic signed [DATA_WIDTH-1:0]  pix;
  logic signed [DATA_WIDTH-1:0]  wgt;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic                          first_tap;
  logic                          last_tap;
  logic                          last_win;

  assign pix_r     = IRW'(row) + IRW'(tap_r);
  assign pix_c     = ICW'(col) + ICW'(tap_c);
  assign pix       = $signed(img_arr[pix_r][pix_c]);
  assign wgt       = $signed(ker_arr[tap_r][tap_c]);
  assign prod      = pix * wgt;
  assign first_tap = (tap_r == '0) && (tap_c == '0);
  assign last_tap  = (tap_r == TR_LAST) && (tap_c == TC_LAST);
  assign last_win  = (row == OR_LAST) && (col == OC_LAST);
  // Tap 0 starts a fresh window, so the old accumulator is dropped there.
  assign sum       = (first_tap ? '0 : acc)
                     + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      image_reg   <= '0;
      ker_reg     <= '0;
      kc          <= '0;
      row         <= '0;
      col         <= '0;
      tap_r       <= '0;
      tap_c       <= '0;
      acc         <= '0;
      next_kernel <= 1'b0;
      out_value   <= '0;
      out_valid   <= 1'b0;
      out_kernel  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            image_reg   <= image_in;
            err_short   <= 1'b0;
            kc          <= '0;
            next_kernel <= 1'b1;
            busy        <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (kernel_valid) begin
            ker_reg     <= kernel_in;
            row         <= '0;
            col         <= '0;
            tap_r       <= '0;
            tap_c       <= '0;
            next_kernel <= 1'b0;
            state       <= S_MAC;
          end else if (weights_done) begin
            err_short   <= 1'b1;
            next_kernel <= 1'b0;
            done        <= 1'b1;
            state       <= S_FIN;
          end
        end
        S_MAC: begin
          acc <= sum;
          if (tap_c == TC_LAST) begin
            tap_c <= '0;
            tap_r <= (tap_r == TR_LAST) ? '0 : tap_r + 1'b1;
          end else begin
            tap_c <= tap_c + 1'b1;
          end
          if (last_tap) begin
`ifdef CONV_MAC_RELU_EN
            out_value <= sum[ACC_WIDTH-1] ? '0 : sum;
`else
            out_value <= sum;
`endif
            out_kernel <= KIW'(kc);
            out_valid  <= 1'b1;
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_win) begin
              kc <= kc + 1'b1;
              if (kc == KC_LAST) begin
                done  <= 1'b1;
                state <= S_FIN;
              end else begin
                next_kernel <= 1'b1;
                state       <= S_REQ;
              end
            end else begin
              if (col == OC_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              state <= S_MAC;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_unit.sv
module tb_conv_mac_unit;
  localparam int DW  = 8;
  localparam int KH  = 3;
  localparam int KW  = 3;
  localparam int NK  = 3;
  localparam int IH  = 5;
  localparam int IW  = 5;
  localparam int ACC = 2*DW+4;
  localparam int OH  = IH-KH+1;
  localparam int OW  = IW-KW+1;
  localparam int KIW = (NK > 1) ? $clog2(NK) : 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 start;
  logic [DW*IH*IW-1:0]  image_in;
  logic [DW*KH*KW-1:0]  kernel_in;
  logic                 kernel_valid;
  logic                 weights_done;
  logic                 next_kernel;
  logic [ACC-1:0]       out_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [KIW-1:0]       out_kernel;
  logic                 busy;
  logic                 done;
  logic                 err_short;
  logic [2:0]           dbg_state;

  conv_mac_unit #(
    .DATA_WIDTH(DW), .K_H(KH), .K_W(KW), .NUM_KERNELS(NK),
    .IMG_H(IH), .IMG_W(IW), .ACC_WIDTH(ACC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .image_in(image_in),
    .kernel_in(kernel_in), .kernel_valid(kernel_valid),
    .weights_done(weights_done), .next_kernel(next_kernel),
    .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_kernel(out_kernel), .busy(busy), .done(done),
    .err_short(err_short), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int img  [IH][IW];
  int kers [NK][KH][KW];
  logic [ACC-1:0] exp_q[$];
  logic [KIW-1:0] expk_q[$];

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW*IH*IW-1:0] pack_img();
    logic [DW*IH*IW-1:0] v;
    v = '0;
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        v[(r*IW+c)*DW +: DW] = DW'(img[r][c]);
    return v;
  endfunction

  function automatic logic [DW*KH*KW-1:0] pack_ker(input int k);
    logic [DW*KH*KW-1:0] v;
    v = '0;
    for (int r = 0; r < KH; r++)
      for (int c = 0; c < KW; c++)
        v[(r*KW+c)*DW +: DW] = DW'(kers[k][r][c]);
    return v;
  endfunction

  function automatic logic [DW*KH*KW-1:0] rand_ker_bits();
    logic [DW*KH*KW-1:0] v;
    v = '0;
    for (int i = 0; i < KH*KW; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic logic [DW*IH*IW-1:0] rand_img_bits();
    logic [DW*IH*IW-1:0] v;
    v = '0;
    for (int i = 0; i < IH*IW; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  function automatic int rand_elem();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Plain 2-D correlation of one window, optionally clamped at zero.
  function automatic longint win_ref(input int k, input int orow, input int ocol);
    longint s;
    s = 0;
    for (int i = 0; i < KH; i++)
      for (int j = 0; j < KW; j++)
        s += longint'(img[orow+i][ocol+j]) * longint'(kers[k][i][j]);
`ifdef CONV_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic build_expected(input int n_ker);
    exp_q.delete();
    expk_q.delete();
    for (int k = 0; k < n_ker && k < NK; k++)
      for (int orow = 0; orow < OH; orow++)
        for (int ocol = 0; ocol < OW; ocol++) begin
          exp_q.push_back(ACC'(win_ref(k, orow, ocol)));
          expk_q.push_back(KIW'(k));
        end
  endtask

  task automatic randomize_data();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) img[r][c] = rand_elem();
    for (int k = 0; k < NK; k++)
      for (int r = 0; r < KH; r++)
        for (int c = 0; c < KW; c++) kers[k][r][c] = rand_elem();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_next_kernel"}, next_kernel, 0);
    chk({tag, "_out_valid"},   out_valid,   0);
    chk({tag, "_out_value"},   out_value,   0);
    chk({tag, "_out_kernel"},  out_kernel,  0);
    chk({tag, "_busy"},        busy,        0);
    chk({tag, "_done"},        done,        0);
    chk({tag, "_err_short"},   err_short,   0);
    chk({tag, "_state"},       dbg_state,   0);
  endtask

  // ---------------- driver / monitor ----------------
  // ready_mode: 0 always ready, 1 random ready, 2 ready low 10 cycles at 4th result.
  // abort_hs >= 0: pull rst_n low in the MAC of window abort_hs (0-based).
  task automatic run_job(input int n_serve, input int ready_mode,
                         input int abort_hs, input bit exp_err,
                         output bit aborted);
    int served, wait_c, hs, cyc, stall_left, abort_wait, total;
    int last_hs_cyc, last_k;
    bit finished, stalled, prev_hold;
    logic [ACC-1:0] prev_val;
    logic [KIW-1:0] prev_k;
    logic [ACC-1:0] ev;
    logic [KIW-1:0] ek;

    build_expected(n_serve);
    total = exp_q.size();
    served = 0; wait_c = $urandom_range(0, 2); hs = 0; cyc = 0;
    stall_left = 0; abort_wait = 0; last_hs_cyc = -1; last_k = -1;
    finished = 0; stalled = 0; prev_hold = 0; aborted = 0;
    prev_val = '0; prev_k = '0;

    while (!finished && cyc < 4000) begin
      @(posedge clk); #1;
      start    = (cyc == 0);
      image_in = (cyc == 0) ? pack_img() : rand_img_bits();
      kernel_valid = 1'b0;
      weights_done = 1'b0;
      if (next_kernel) begin
        if (wait_c > 0) wait_c--;
        else if (served < n_serve) begin
          kernel_valid = 1'b1;
          kernel_in    = pack_ker(served);
          served++;
          wait_c = $urandom_range(0, 2);
        end else weights_done = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        kernel_valid = 1'b1;             // stray pulse outside a request
        kernel_in    = rand_ker_bits();
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && hs == 3 && !stalled) begin
            stall_left = 10;
            stalled = 1;
          end
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
      endcase
      if (abort_hs >= 0 && hs == abort_hs) begin
        abort_wait++;
        if (abort_wait == 3) begin
          chk("abort_in_mac", dbg_state, 2);
          rst_n = 1'b0;
          #1;
          check_all_zero("abort");
          @(posedge clk); #1;
          @(posedge clk); #1;
          kernel_valid = 1'b0;
          start = 1'b0;
          rst_n = 1'b1;
          aborted = 1;
          return;
        end
      end

      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("err_clear_on_start", err_short, 0);
      if (prev_hold) begin
        chk("hold_valid",  out_valid,  1);
        chk("hold_value",  out_value,  prev_val);
        chk("hold_kernel", out_kernel, prev_k);
      end
      prev_hold = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) chk("extra_result", 1, 0);
          else begin
            ev = exp_q.pop_front();
            ek = expk_q.pop_front();
            chk("out_value",  $signed(out_value), $signed(ev));
            chk("out_kernel", out_kernel, ek);
            if (ready_mode == 0 && last_k == int'(out_kernel) && last_hs_cyc >= 0)
              chk("result_interval", cyc - last_hs_cyc, KH*KW+1);
          end
          last_hs_cyc = cyc;
          last_k = int'(out_kernel);
          hs++;
        end else begin
          prev_hold = 1;
          prev_val  = out_value;
          prev_k    = out_kernel;
        end
      end
      if (done) begin
        chk("done_after_last", exp_q.size(), 0);
        chk("err_short",       err_short, exp_err);
        chk("busy_in_fin",     busy, 1);
        finished = 1;
      end
    end

    if (!finished) chk("job_timeout", 0, 1);
    chk("result_count", hs, total);
    @(posedge clk); #1;
    kernel_valid = 1'b0;
    weights_done = 1'b0;
    @(negedge clk);
    chk("done_single_cycle", done, 0);
    chk("idle_not_busy",     busy, 0);
    chk("idle_no_valid",     out_valid, 0);
    chk("err_sticky",        err_short, exp_err);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ab;
    rst_n = 1'b0; start = 1'b0; image_in = '0; kernel_in = '0;
    kernel_valid = 1'b0; weights_done = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all-ones image and kernels: every window sums to 9
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = 1;
    for (int k = 0; k < NK; k++)
      for (int r = 0; r < KH; r++) for (int c = 0; c < KW; c++) kers[k][r][c] = 1;
    run_job(NK, 0, -1, 0, ab);

    // ramp image, centre-tap-only kernel 0
    randomize_data();
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = r*IW + c;
    for (int r = 0; r < KH; r++) for (int c = 0; c < KW; c++) kers[0][r][c] = 0;
    kers[0][1][1] = 2;
    run_job(NK, 0, -1, 0, ab);

    // most negative product corner
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) img[r][c] = -128;
    for (int k = 0; k < NK; k++)
      for (int r = 0; r < KH; r++) for (int c = 0; c < KW; c++) kers[k][r][c] = 127;
    run_job(NK, 1, -1, 0, ab);

    // back-pressure at the 4th result
    randomize_data();
    run_job(NK, 2, -1, 0, ab);

    // weight stage runs out after one kernel
    randomize_data();
    run_job(1, 0, -1, 1, ab);
    repeat (3) @(negedge clk);
    chk("err_sticky_idle", err_short, 1);

    // reset in the MAC of the 5th window, then a clean rerun
    randomize_data();
    run_job(NK, 0, 4, 0, ab);
    chk("aborted", ab, 1);
    @(negedge clk);
    check_all_zero("post_abort");
    run_job(NK, 1, -1, 0, ab);

    for (int j = 0; j < 3; j++) begin
      randomize_data();
      run_job(NK, 1, -1, 0, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
